regfile_mp: RTL

Parametrised multi-port register file, the flip-flop successor to the single-write latch register file. It provides configurable depth, width, read ports and write ports, with deterministic write-port priority. A registered write stage with optional read bypass improves timing closure. A bulk-clear state machine zeroes the whole array without a reset tree on the storage. It sits in the core between rename/commit and operand read, and its full-array dump port feeds debug/trace.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_clear_fsm.sv | 57 +++++
 rtl/regfile_mp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port flip-flop register file.
package regfile_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  localparam int unsigned MAX_WRITE_PORTS = 8;

  function automatic int unsigned num_words(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One-hot select of the highest-index asserted match; higher port wins.
  function automatic logic [MAX_WRITE_PORTS-1:0] wsel_onehot(
    input logic [MAX_WRITE_PORTS-1:0] match
  );
    logic [MAX_WRITE_PORTS-1:0] sel;
    sel = '0;
    for (int unsigned p = 0; p < MAX_WRITE_PORTS; p++) begin
      if (match[p]) begin
        sel    = '0;
        sel[p] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps every entry once after reset or a clear request.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clr_start_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    busy_o      = 1'b0;
    clr_start_o = 1'b0;
    clr_we_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d     = CLEAR;
          clr_idx_d   = '0;
          clr_start_o = 1'b1;
        end
      end
      CLEAR: begin
        busy_o    = 1'b1;
        clr_we_o  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_addr_o = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port flip-flop register file with registered write stage and bulk clear.
// Define REGFILE_BYPASS_EN to forward staged writes onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          clear_i,
  output logic                                          busy_o,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]      raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]      rdata_o,
  output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]      rdata_full_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]     waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                     we_i
);

  localparam int unsigned NUM_WORDS = num_words(ADDR_WIDTH);

  logic                  busy;
  logic                  clr_start;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  commit_ok;

  logic [NR_WRITE_PORTS-1:0]                 we_q;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_q;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic [NUM_WORDS-1:0]                 commit_en;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] commit_data;

  regfile_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .busy_o      (busy),
    .clr_start_o (clr_start),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  assign busy_o = busy;

  // A clear accepted this cycle drops both the incoming and the pending write.
  assign commit_ok = !busy && !clr_start && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || busy || clr_start) begin
      we_q <= '0;
    end else begin
      we_q <= we_i;
    end
    waddr_q <= waddr_i;
    wdata_q <= wdata_i;
  end

  always_comb begin
    logic [MAX_WRITE_PORTS-1:0] match;
    logic [MAX_WRITE_PORTS-1:0] sel;
    commit_en   = '0;
    commit_data = '0;
    match       = '0;
    sel         = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      match = '0;
      for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
        match[p] = we_q[p] && (waddr_q[p] == ADDR_WIDTH'(i));
      end
      sel = wsel_onehot(match);
      for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
        if (sel[p]) begin
          commit_data[i] = wdata_q[p];
        end
      end
      commit_en[i] = commit_ok && (|match) && !(ZERO_REG_ZERO && (i == 0));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (clr_we && (clr_addr == ADDR_WIDTH'(i))) begin
        mem_q[i] <= '0;
      end else if (commit_en[i]) begin
        mem_q[i] <= commit_data[i];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      if (!busy && !(ZERO_REG_ZERO && (raddr_i[r] == '0))) begin
        rdata_o[r] = mem_q[raddr_i[r]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
          if (we_q[p] && (waddr_q[p] == raddr_i[r])) begin
            rdata_o[r] = wdata_q[p];
          end
        end
`endif
      end
    end
  end

  always_comb begin
    rdata_full_o = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      rdata_full_o[i] = (ZERO_REG_ZERO && (i == 0)) ? '0 : mem_q[i];
    end
  end

endmodule
